// File: rtl/river_pkg.sv
// Shared definitions for the wolf/goat/cabbage river crossing controller.
//   move_e    : cargo carried on a crossing (NONE = man crosses alone)
//   state_e   : controller FSM states
//   LAST_STEP : index of the final move in a solution
//   SOL_*     : the two built-in solutions, 2 bits per move, step 0 in the LSBs
package river_pkg;

  localparam int unsigned STEP_W    = 3;
  localparam int unsigned NUM_STEPS = 7;
  localparam logic [STEP_W-1:0] LAST_STEP = 3'd6;

  typedef enum logic [1:0] {
    MV_NONE = 2'd0,
    MV_W    = 2'd1,
    MV_G    = 2'd2,
    MV_C    = 2'd3
  } move_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Written step 6 first so that step 0 lands in bits [1:0].
  localparam logic [2*NUM_STEPS-1:0] SOL_WOLF_FIRST =
    {MV_G, MV_NONE, MV_C, MV_G, MV_W, MV_NONE, MV_G};
  localparam logic [2*NUM_STEPS-1:0] SOL_CABBAGE_FIRST =
    {MV_G, MV_NONE, MV_W, MV_G, MV_C, MV_NONE, MV_G};

  // Move presented at a given step of the selected solution.
  function automatic move_e sol_move(input logic variant, input logic [STEP_W-1:0] idx);
    logic [2*NUM_STEPS-1:0] tbl;
    tbl = variant ? SOL_CABBAGE_FIRST : SOL_WOLF_FIRST;
    if (idx > LAST_STEP) return MV_NONE;
    return move_e'(tbl[2*int'(idx) +: 2]);
  endfunction

  // Something gets eaten when left with its prey away from the man.
  function automatic logic is_unsafe(input logic w, input logic g, input logic c, input logic m);
    return ((w == g) && (w != m)) || ((g == c) && (g != m));
  endfunction

endpackage

// File: rtl/river_bank_model.sv
// Tracks which bank each of wolf, goat, cabbage and man is on, and latches a
// sticky safety-violation flag.
//   clk, rst_n      : clock, async active-low reset
//   clr_i           : put everything back on the start bank
//   clr_unsafe_i    : clear the sticky unsafe flag
//   move_i          : one crossing happens this cycle
//   sel_w/g/c_i     : one-hot cargo of that crossing (all low = man alone)
//   bank_*_o        : 0 = start bank, 1 = far bank
//   unsafe_o        : a violating arrangement has been reached
module river_bank_model
  import river_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic clr_unsafe_i,
  input  logic move_i,
  input  logic sel_w_i,
  input  logic sel_g_i,
  input  logic sel_c_i,
  output logic bank_w_o,
  output logic bank_g_o,
  output logic bank_c_o,
  output logic bank_m_o,
  output logic unsafe_o
);

  logic w_q, g_q, c_q, m_q, unsafe_q;
  logic w_d, g_d, c_d, m_d, unsafe_d;

  // Next bank state: cargo only travels if it is standing next to the man.
  always_comb begin
    w_d      = w_q;
    g_d      = g_q;
    c_d      = c_q;
    m_d      = m_q;
    unsafe_d = unsafe_q;
    if (clr_i) begin
      w_d = 1'b0;
      g_d = 1'b0;
      c_d = 1'b0;
      m_d = 1'b0;
    end else if (move_i) begin
      m_d = ~m_q;
      if (sel_w_i && (w_q == m_q)) w_d = ~m_q;
      if (sel_g_i && (g_q == m_q)) g_d = ~m_q;
      if (sel_c_i && (c_q == m_q)) c_d = ~m_q;
    end
    if (clr_unsafe_i) begin
      unsafe_d = 1'b0;
    end else if (move_i && !clr_i) begin
      unsafe_d = unsafe_q | is_unsafe(w_d, g_d, c_d, m_d);
    end
  end

  // Bank and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q      <= 1'b0;
      g_q      <= 1'b0;
      c_q      <= 1'b0;
      m_q      <= 1'b0;
      unsafe_q <= 1'b0;
    end else begin
      w_q      <= w_d;
      g_q      <= g_d;
      c_q      <= c_d;
      m_q      <= m_d;
      unsafe_q <= unsafe_d;
    end
  end

  assign bank_w_o = w_q;
  assign bank_g_o = g_q;
  assign bank_c_o = c_q;
  assign bank_m_o = m_q;
  assign unsafe_o = unsafe_q;

endmodule

// File: rtl/river_crossing_ctrl.sv
// Presents the 7-move river crossing solution over a valid/ready handshake and
// tracks the resulting bank positions.
//   VARIANT          : 0 = wolf carried first, 1 = cabbage carried first
//   clk, rst_n       : clock, async active-low reset
//   start, abort     : begin a sequence (IDLE/DONE) / cancel it (SEND)
//   mv_valid/ready   : move handshake; mv_w/g/c one-hot cargo, step = move index
//   bank_w/g/c/m     : tracked banks (0 = start, 1 = far)
//   busy/done/unsafe : in SEND / in DONE / sticky safety violation
module river_crossing_ctrl
  import river_pkg::*;
#(
  parameter int unsigned VARIANT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic              mv_w,
  output logic              mv_g,
  output logic              mv_c,
  output logic              bank_w,
  output logic              bank_g,
  output logic              bank_c,
  output logic              bank_m,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic              unsafe
);

  localparam logic VAR_SEL = (VARIANT != 0);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              valid_q, busy_q, done_q;
  logic [2:0]        sel_q, sel_d;
  move_e             mv_d;
  logic              move_c, bank_clr_c, unsafe_clr_c;

  // Sequencing; abort takes priority over a same-cycle handshake.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    move_c       = 1'b0;
    bank_clr_c   = 1'b0;
    unsafe_clr_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_SEND;
          step_d       = '0;
          bank_clr_c   = 1'b1;
          unsafe_clr_c = 1'b1;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d    = ST_IDLE;
          step_d     = '0;
          bank_clr_c = 1'b1;
        end else if (mv_ready) begin
          move_c = 1'b1;
          if (step_q == LAST_STEP) state_d = ST_DONE;
          else                     step_d  = step_q + STEP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
    mv_d  = (state_d == ST_SEND) ? sol_move(VAR_SEL, step_d) : MV_NONE;
    sel_d = {mv_d == MV_W, mv_d == MV_G, mv_d == MV_C};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      valid_q <= (state_d == ST_SEND);
      busy_q  <= (state_d == ST_SEND);
      done_q  <= (state_d == ST_DONE);
      sel_q   <= sel_d;
    end
  end

  river_bank_model u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (bank_clr_c),
    .clr_unsafe_i (unsafe_clr_c),
    .move_i       (move_c),
    .sel_w_i      (sel_q[2]),
    .sel_g_i      (sel_q[1]),
    .sel_c_i      (sel_q[0]),
    .bank_w_o     (bank_w),
    .bank_g_o     (bank_g),
    .bank_c_o     (bank_c),
    .bank_m_o     (bank_m),
    .unsafe_o     (unsafe)
  );

  assign mv_valid = valid_q;
  assign mv_w     = sel_q[2];
  assign mv_g     = sel_q[1];
  assign mv_c     = sel_q[0];
  assign step     = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/river_crossing_ctrl.md
RIVER_CROSSING_CTRL -- requirements
Module: river_crossing_ctrl

Interface
REQ-001 SHALL have parameter VARIANT, default 0, meaning solution selector (0 = wolf carried first, 1 = cabbage carried first).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  begin a crossing sequence (sampled in IDLE or DONE only).
REQ-005 SHALL have port abort  input  1  cancel an in-progress sequence.
REQ-006 SHALL have port mv_valid  output  1  a move is presented.
REQ-007 SHALL have port mv_ready  input  1  consumer accepts the presented move.
REQ-008 SHALL have port mv_w, mv_g, mv_c  output  1 each  one-hot cargo select for the current crossing; all low means the man crosses alone.
REQ-009 SHALL have port bank_w, bank_g, bank_c, bank_m  output  1 each  tracked bank (0 = start, 1 = far) of wolf, goat, cabbage, man.
REQ-010 SHALL have port step  output  3  index of the presented move, 0..6.
REQ-011 SHALL have port busy, done, unsafe  output  1 each  sequence active / sequence complete / safety violation latched.

Function
REQ-012 SHALL implement FSM states IDLE, SEND, DONE.
REQ-013 SHALL, in IDLE or DONE, on start=1, clear all banks to 0, set step=0, and enter SEND the next cycle.
REQ-014 SHALL, in SEND, hold mv_valid=1 and keep mv_w/g/c and step stable until mv_valid && mv_ready.
REQ-015 SHALL present sequence G,-,W,G,C,-,G for VARIANT=0 and G,-,C,G,W,-,G for VARIANT=1 ('-' = all selects low).
REQ-016 SHALL, on handshake, update banks the following cycle: bank_m toggles; the selected item moves to !bank_m only if it is on the man's bank.
REQ-017 SHALL, on handshake at step 6, enter DONE; otherwise increment step; step never wraps past 6.
REQ-018 SHALL drive mv_valid=0 and mv_w/g/c=0 in IDLE and DONE.
REQ-019 SHALL assert busy only in SEND, and assert done only in DONE, holding it until start or reset.
REQ-020 SHALL ignore start while in SEND.
REQ-021 SHALL, on abort in SEND, enter IDLE the next cycle, clear banks and step, and drop the current move even if mv_ready=1 that cycle (abort wins).
REQ-022 SHALL set unsafe, sticky until start or reset, when an updated state has (bank_w==bank_g && bank_w!=bank_m) or (bank_g==bank_c && bank_g!=bank_m).
REQ-023 SHALL leave unsafe at 0 for every state of both built-in sequences.
REQ-024 SHALL reach DONE with bank_w=bank_g=bank_c=bank_m=1 after exactly 7 handshakes.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state=IDLE, step=0, all banks=0, mv_valid=0, mv_w/g/c=0, busy=0, done=0, unsafe=0.
REQ-026 SHALL, on reset mid-sequence, discard all progress; the first handshake after a new start is step 0.

Structure
REQ-027 SHALL place the move encoding (NONE, W, G, C), the FSM state enum, the constant LAST_STEP=6, and both solution tables in shared package river_pkg.
REQ-028 SHALL implement bank tracking and the safety check in sub-module river_bank_model, which takes a move strobe and cargo selects and outputs the four banks and an unsafe flag.

Verification
REQ-029 SHALL cover this scenario: reset, then hold mv_ready=1 and pulse start -> 7 consecutive handshakes with cargo G,-,W,G,C,-,G; done=1 on the cycle after the 7th; banks all 1; unsafe=0.
REQ-030 SHALL cover this scenario: VARIANT=1 with mv_ready toggling 1/0 each cycle -> cargo G,-,C,G,W,-,G; outputs stable during ready=0; done after 7 handshakes.
REQ-031 SHALL cover this scenario: mv_ready=0 for 10 cycles at step 2 -> mv_w=1, step=2, and banks unchanged throughout.
REQ-032 SHALL cover this scenario: abort asserted together with mv_ready=1 at step 4 -> IDLE next cycle, banks 0, step 0, mv_valid=0.
REQ-033 SHALL cover this scenario: rst_n pulsed low at step 5 -> all outputs at reset values immediately; a new start replays from step 0 with G.
REQ-034 SHALL cover this scenario: start pulsed in DONE -> banks cleared, done=0, busy=1, and the sequence repeats identically.
